// File: rtl/bias_loader.sv
// bias_loader: receives DEPTH bias words as a byte stream (high byte first)
// into a register file, with an asynchronous combinational read port.
module bias_loader #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    input  logic [7:0]       ra1,
    output logic [WIDTH-1:0] rd1,
    output logic             loaded,
    output logic             done
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV_HI,
        RECV_LO,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [7:0]       hi;
    logic [WIDTH-1:0] rf [DEPTH];
    logic             xfer;

    assign xfer = in_valid && in_ready;

    // Load FSM: byte assembly, register-file writes and registered status outputs.
    // start is checked before the state case so it wins over a same-cycle byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            loaded   <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[CW'(i)] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= RECV_HI;
                count    <= '0;
                hi       <= '0;
                loaded   <= 1'b0;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    RECV_HI: begin
                        if (xfer) begin
                            hi    <= in_byte;
                            state <= RECV_LO;
                        end
                    end
                    RECV_LO: begin
                        if (xfer) begin
                            rf[count] <= WIDTH'({hi, in_byte});
                            if (count == CW'(DEPTH - 1)) begin
                                state    <= DONE;
                                loaded   <= 1'b1;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                count <= count + 1'b1;
                                state <= RECV_HI;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for start; in_valid is ignored
                    end
                endcase
            end
        end
    end

    // Read port: registered contents, zero for addresses beyond DEPTH-1.
    always_comb begin
        rd1 = '0;
        if (32'(ra1) < DEPTH) begin
            rd1 = rf[ra1[CW-1:0]];
        end
    end

endmodule

// File: doc/bias_loader.md
BIAS_LOADER -- requirements
Module: bias_loader

Interface
REQ-001 Parameter DEPTH, default 15, number of bias entries.
REQ-002 Parameter WIDTH, default 16, bias word width in bits; byte count per word is fixed at 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-005 start  input  1  one-cycle pulse that begins or restarts a load of DEPTH words.
REQ-006 in_valid  input  1  in_byte carries a valid byte this cycle.
REQ-007 in_byte  input  8  serial bias byte, high byte of each word first.
REQ-008 in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 ra1  input  8  read address.
REQ-010 rd1  output  WIDTH  combinational read data for ra1.
REQ-011 loaded  output  1  level: all DEPTH entries written since the last start.
REQ-012 done  output  1  one-cycle pulse when the final word is written.

Function
REQ-013 A byte transfer occurs when in_valid and in_ready are both 1 on a rising clk edge; no other byte is consumed.
REQ-014 The FSM has states IDLE, RECV_HI, RECV_LO and DONE.
REQ-015 in_ready is 1 in RECV_HI and RECV_LO only, and 0 in IDLE and DONE.
REQ-016 IDLE: start moves the FSM to RECV_HI, clears the word counter to 0 and clears loaded; in_valid is ignored.
REQ-017 RECV_HI: on a transfer, in_byte latches into the hi register and the FSM moves to RECV_LO.
REQ-018 RECV_LO: on a transfer, rf[count] is written with {hi, in_byte} on that edge.
REQ-019 RECV_LO: if count == DEPTH-1, the FSM moves to DONE; otherwise count increments and the FSM returns to RECV_HI.
REQ-020 On the RECV_LO->DONE edge, loaded becomes 1 and done is 1 for exactly the following cycle.
REQ-021 DONE holds until start, which behaves as in IDLE; rf contents are kept until overwritten.
REQ-022 start in RECV_HI or RECV_LO aborts the load: count=0, FSM=RECV_HI, and any partially latched hi byte is discarded.
REQ-023 start has priority over a simultaneous byte transfer, and that byte is not consumed.
REQ-024 Word counter width is $clog2(DEPTH); it never exceeds DEPTH-1 and never wraps.
REQ-025 rd1 = rf[ra1] when ra1 < DEPTH, else rd1 = 0.
REQ-026 rd1 is independent of FSM state: reads during a load return the current contents, which may be a mix of old and new words.
REQ-027 A write and a read of the same address in one cycle returns the old value, because rd1 reflects the registered contents.
REQ-028 Stalls (in_valid=0) in any RECV state hold all state indefinitely.

Reset
REQ-029 While rst_n=0: FSM=IDLE, count=0, hi=0, all rf entries=0, loaded=0, done=0, in_ready=0.
REQ-030 Reset asserted mid-load discards the load, and all effects of REQ-029 apply immediately without waiting for clk.

Verification
REQ-031 Reset, then start, then 30 back-to-back bytes 0x00,0x01,...,0x1D -> rf[k] = {2k, 2k+1} (rf[0]=0x0001, rf[14]=0x1C1D); done pulses one cycle after the 30th byte; loaded=1.
REQ-032 Same load with in_valid toggling every other cycle -> identical rf contents; in_ready=1 throughout the RECV states; done pulses once.
REQ-033 After a full load, start, then 5 bytes, then start again, then 30 bytes 0xA0+ -> partial hi discarded; final rf matches the second stream only; loaded=0 between the two starts.
REQ-034 ra1=15 and ra1=0xFF -> rd1=0x0000; ra1=14 after REQ-031 -> rd1=0x1C1D.
REQ-035 rst_n pulsed low after 11 bytes, then in_valid=1 with no start -> in_ready=0, no writes, rd1=0 for all addresses, loaded=0.
REQ-036 start and in_valid high in the same cycle in RECV_HI -> byte not consumed, count=0, and the next transfer lands as the hi byte of rf[0].
